// File: rtl/vga_pkg.sv
// Screen geometry and pixel types shared by the frame buffer, blankboard and the other drawers.
// pix_addr maps (x,y) to a linear frame buffer address.
package vga_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;
    localparam int ADDR_W   = 15;
    localparam int FB_DEPTH = SCREEN_W * SCREEN_H;

    typedef logic [COLOUR_W-1:0] colour_t;

    // Widen both operands first so y*SCREEN_W is never truncated to Y_W bits.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [X_W-1:0] x,
                                                   input logic [Y_W-1:0] y);
        return ADDR_W'(y) * ADDR_W'(SCREEN_W) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port frame buffer memory: one synchronous write port and one synchronous read port.
// Both ports use non-blocking updates, so a same-address read and write in one cycle returns the old data.
module fb_ram
    import vga_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  colour_t           wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output colour_t           rdata
);

    colour_t mem [FB_DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/plot_framebuffer.sv
// Frame buffer sink for the VGA plot interface, with a raster-order scan-out port.
// It counts accepted plots and keeps a sticky flag for plots with out-of-range coordinates.
module plot_framebuffer
    import vga_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [X_W-1:0]      vga_x,
    input  logic [Y_W-1:0]      vga_y,
    input  colour_t             vga_colour,
    input  logic                vga_plot,
    input  logic                scan_en,
    output logic [X_W-1:0]      scan_x,
    output logic [Y_W-1:0]      scan_y,
    output colour_t             scan_colour,
    output logic                scan_valid,
    output logic                frame_start,
    output logic [ADDR_W-1:0]   plot_count,
    output logic                oob_err
);

    localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);

    logic              in_range;
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [X_W-1:0]    sx;
    logic [Y_W-1:0]    sy;
    colour_t           rd_data;
    logic              has_data;

    assign in_range = (vga_x <= X_LAST) && (vga_y <= Y_LAST);
    // A plot presented while reset is held is dropped.
    assign wr_en    = vga_plot && in_range && !rst;
    assign rd_en    = scan_en && !rst;
    assign wr_addr  = pix_addr(vga_x, vga_y);
    assign rd_addr  = pix_addr(sx, sy);

    fb_ram u_fb_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (vga_colour),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sx <= '0;
            sy <= '0;
        end else if (scan_en) begin
            if (sx == X_LAST) begin
                sx <= '0;
                sy <= (sy == Y_LAST) ? '0 : sy + 1'b1;
            end else begin
                sx <= sx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_valid <= 1'b0;
            scan_x     <= '0;
            scan_y     <= '0;
            has_data   <= 1'b0;
        end else begin
            scan_valid <= scan_en;
            if (scan_en) begin
                scan_x   <= sx;
                scan_y   <= sy;
                has_data <= 1'b1;
            end
        end
    end

    // The RAM output register has no reset, so it is masked until a read follows reset.
    assign scan_colour = has_data ? rd_data : '0;
    assign frame_start = scan_valid && (scan_x == '0) && (scan_y == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            plot_count <= '0;
            oob_err    <= 1'b0;
        end else begin
            if (wr_en && (plot_count != '1))
                plot_count <= plot_count + 1'b1;
            if (vga_plot && !in_range)
                oob_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_plot_framebuffer.sv
// Scoreboard bench for plot_framebuffer: scan requests push expected pixels, and a negedge monitor pops and compares them.
// Directed sequence: single plot, out-of-range plots, full sweep, multi-frame scan, same-cycle read/write, and mid-frame reset.
module tb_plot_framebuffer;
    import vga_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [X_W-1:0]    vga_x;
    logic [Y_W-1:0]    vga_y;
    colour_t           vga_colour;
    logic              vga_plot;
    logic              scan_en;
    logic [X_W-1:0]    scan_x;
    logic [Y_W-1:0]    scan_y;
    colour_t           scan_colour;
    logic              scan_valid;
    logic              frame_start;
    logic [ADDR_W-1:0] plot_count;
    logic              oob_err;

    typedef struct {
        int x;
        int y;
        int colour;
        bit known;
        bit fs;
    } exp_t;

    exp_t    sb_q[$];
    exp_t    mon_e;
    int      checks = 0;
    int      errors = 0;
    int      model_mem [160*120];
    bit      model_known [160*120];
    int      msx = 0;
    int      msy = 0;
    bit      count_fs = 0;
    int      out_idx = 0;
    int      fs_count = 0;
    int      fs_first = 0;
    int      fs_second = 0;
    int      last_x = 0;
    int      last_y = 0;
    int      last_c = 0;

    plot_framebuffer dut (
        .clk         (clk),
        .rst         (rst),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot),
        .scan_en     (scan_en),
        .scan_x      (scan_x),
        .scan_y      (scan_y),
        .scan_colour (scan_colour),
        .scan_valid  (scan_valid),
        .frame_start (frame_start),
        .plot_count  (plot_count),
        .oob_err     (oob_err)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Called at posedge+1; drives one cycle of inputs, updates the model, returns at the next posedge+1.
    task automatic apply_stimulus(input bit plot, input int px, input int py, input int pc, input bit scan);
        vga_plot   = plot;
        vga_x      = X_W'(px);
        vga_y      = Y_W'(py);
        vga_colour = COLOUR_W'(pc);
        scan_en    = scan;
        if (scan) begin
            exp_t e;
            e.x      = msx;
            e.y      = msy;
            e.colour = model_mem[msy*160 + msx];
            e.known  = model_known[msy*160 + msx];
            e.fs     = (msx == 0) && (msy == 0);
            sb_q.push_back(e);
            if (msx == 159) begin
                msx = 0;
                msy = (msy == 119) ? 0 : msy + 1;
            end else begin
                msx = msx + 1;
            end
        end
        if (plot && px < 160 && py < 120) begin
            model_mem[py*160 + px]   = pc;
            model_known[py*160 + px] = 1'b1;
        end
        @(posedge clk);
        #1;
        vga_plot = 1'b0;
        scan_en  = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check_output(name, sb_q.size(), 0);
    endtask

    // Monitor: compare every presented pixel against the oldest expectation.
    always @(negedge clk) begin
        if (scan_valid) begin
            if (sb_q.size() == 0) begin
                check_output("unexpected_pixel", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check_output("scan_x", int'(scan_x), mon_e.x);
                check_output("scan_y", int'(scan_y), mon_e.y);
                check_output("frame_start", int'(frame_start), int'(mon_e.fs));
                if (mon_e.known)
                    check_output("scan_colour", int'(scan_colour), mon_e.colour);
                last_x = int'(scan_x);
                last_y = int'(scan_y);
                last_c = int'(scan_colour);
                if (count_fs && out_idx < 38400) begin
                    out_idx++;
                    if (frame_start) begin
                        fs_count++;
                        if (fs_count == 1) fs_first = out_idx;
                        if (fs_count == 2) fs_second = out_idx;
                    end
                end
            end
        end
    end

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 160*120; i++) begin
            model_mem[i]   = 0;
            model_known[i] = 1'b0;
        end
        rst        = 1'b1;
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        vga_plot   = 1'b0;
        scan_en    = 1'b0;
        #2;
        check_output("rst_scan_valid", int'(scan_valid), 0);
        check_output("rst_scan_x", int'(scan_x), 0);
        check_output("rst_scan_y", int'(scan_y), 0);
        check_output("rst_scan_colour", int'(scan_colour), 0);
        check_output("rst_frame_start", int'(frame_start), 0);
        check_output("rst_plot_count", int'(plot_count), 0);
        check_output("rst_oob_err", int'(oob_err), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] single plot at (5,7) then scan 1126 pixels");
        apply_stimulus(1, 5, 7, 5, 0);
        check_output("t1_plot_count", int'(plot_count), 1);
        for (int i = 0; i < 1126; i++)
            apply_stimulus(0, 0, 0, 0, 1);
        drain("t1_drain");
        check_output("t1_last_x", last_x, 5);
        check_output("t1_last_y", last_y, 7);
        check_output("t1_last_colour", last_c, 5);

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        msx = 0;
        msy = 0;
        check_output("t5_plot_count_cleared", int'(plot_count), 0);

        $display("[TB] full-screen sweep of colour 010");
        for (int y = 0; y < 120; y++)
            for (int x = 0; x < 160; x++)
                apply_stimulus(1, x, y, 2, 0);
        check_output("t5_plot_count", int'(plot_count), 19200);

        $display("[TB] out-of-range plots");
        check_output("t2_oob_before", int'(oob_err), 0);
        apply_stimulus(1, 160, 0, 7, 0);
        check_output("t2_oob_x", int'(oob_err), 1);
        apply_stimulus(1, 0, 120, 7, 0);
        apply_stimulus(0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("t2_oob_sticky", int'(oob_err), 1);
        check_output("t2_plot_count", int'(plot_count), 19200);

        $display("[TB] continuous scan across frames with same-cycle plot at (0,0)");
        out_idx  = 0;
        fs_count = 0;
        count_fs = 1'b1;
        for (int i = 0; i < 48080; i++) begin
            if (i == 5)
                apply_stimulus(1, 0, 0, 0, 1);
            else if (i == 19200)
                apply_stimulus(1, 0, 0, 3, 1);
            else
                apply_stimulus(0, 0, 0, 0, 1);
        end
        drain("t3_drain");
        count_fs = 1'b0;
        check_output("t3_fs_count", fs_count, 2);
        check_output("t3_fs_first", fs_first, 1);
        check_output("t3_fs_second", fs_second, 19201);
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("hold_scan_valid", int'(scan_valid), 0);
        check_output("hold_scan_x", int'(scan_x), 79);
        check_output("hold_scan_y", int'(scan_y), 60);
        check_output("hold_scan_colour", int'(scan_colour), 2);

        $display("[TB] reset mid-frame at (80,60) with a plot in the reset cycle");
        rst        = 1'b1;
        vga_plot   = 1'b1;
        vga_x      = X_W'(1);
        vga_y      = Y_W'(0);
        vga_colour = 3'b111;
        #2;
        check_output("t6_async_scan_x", int'(scan_x), 0);
        check_output("t6_async_scan_y", int'(scan_y), 0);
        check_output("t6_async_scan_colour", int'(scan_colour), 0);
        check_output("t6_async_plot_count", int'(plot_count), 0);
        check_output("t6_async_oob_err", int'(oob_err), 0);
        @(posedge clk);
        #1;
        vga_plot = 1'b0;
        rst      = 1'b0;
        msx      = 0;
        msy      = 0;
        check_output("t6_dropped_plot_count", int'(plot_count), 0);
        for (int i = 0; i < 3; i++)
            apply_stimulus(0, 0, 0, 0, 1);
        drain("t6_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
